// File: rtl/seg_display_scanner.sv
// Four-digit common-anode 7-segment scan controller.
// Rotates anodes with a blanking gap and latches data once per frame.
module seg_display_scanner #(
  parameter int DIV       = 100000,
  parameter int BLANK_CYC = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] digits_in,
  input  logic [3:0]  digit_en,
  input  logic [3:0]  dp_in,
  input  logic        lz_en,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        frame_done
);

  localparam int MAXC = (DIV > BLANK_CYC) ? DIV : BLANK_CYC;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] BLK_LAST =
    CW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);

  typedef enum logic {BLANK, SHOW} phase_t;
  localparam phase_t START = (BLANK_CYC == 0) ? SHOW : BLANK;

  phase_t        phase;
  logic [1:0]    slot;
  logic [CW-1:0] cnt;

  logic [15:0] digits_q;
  logic [3:0]  en_q;
  logic [3:0]  dp_q;
  logic        lz_q;

  logic        load;
  logic [15:0] eff_digits;
  logic [3:0]  eff_en;
  logic [3:0]  eff_dp;
  logic        eff_lz;
  logic [3:0]  sup;
  logic [3:0]  lit;
  logic [3:0]  nib;
  logic        on;

  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // The loading edge already drives slot 0 when BLANK_CYC is 0,
  // so outputs see the incoming values on that edge.
  assign load = (slot == 2'd0) && (phase == START) && (cnt == '0);

  assign eff_digits = load ? digits_in : digits_q;
  assign eff_en     = load ? digit_en  : en_q;
  assign eff_dp     = load ? dp_in     : dp_q;
  assign eff_lz     = load ? lz_en     : lz_q;

  always_comb begin
    sup    = 4'b0000;
    sup[3] = eff_lz && (eff_digits[15:12] == 4'h0);
    sup[2] = sup[3] && (eff_digits[11:8] == 4'h0);
    sup[1] = sup[2] && (eff_digits[7:4] == 4'h0);
  end

  assign lit = eff_en & ~sup;
  assign nib = eff_digits[{slot, 2'b00} +: 4];
  assign on  = (phase == SHOW) && lit[slot];

  always_ff @(posedge clk) begin
    if (reset) begin
      phase      <= START;
      slot       <= 2'd0;
      cnt        <= '0;
      digits_q   <= '0;
      en_q       <= '0;
      dp_q       <= '0;
      lz_q       <= 1'b0;
      an         <= 4'b1111;
      seg        <= 7'b1111111;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      if (load) begin
        digits_q <= digits_in;
        en_q     <= digit_en;
        dp_q     <= dp_in;
        lz_q     <= lz_en;
      end

      if (phase == BLANK) begin
        if (cnt == BLK_LAST) begin
          phase <= SHOW;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        if (cnt == DIV_LAST) begin
          phase <= START;
          cnt   <= '0;
          slot  <= slot + 2'd1;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end

      an  <= on ? ~(4'b0001 << slot) : 4'b1111;
      seg <= on ? decode(nib) : 7'b1111111;
      dp  <= ~(on && eff_dp[slot]);
      frame_done <= (slot == 2'd3) && (phase == SHOW) &&
                    (cnt == DIV_LAST);
    end
  end

endmodule
